// File: rtl/ram_rd_sched.sv
// ram_rd_sched: round-robin read scheduler for the double-banked LED frame RAM.
// Arbitrates the single RAM read port among channel engines, tags each read
// with its requester so returned data can be steered back, and flips the
// display bank once all in-flight reads have drained after a completed frame.
module ram_rd_sched #(
  parameter int CHAN_NUM = 16,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  localparam int CW      = $clog2(CHAN_NUM)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       ram_wr_done_i,
  input  logic [CHAN_NUM-1:0]        req_i,
  input  logic [CHAN_NUM*ADDR_W-1:0] req_addr_i,
  output logic [CHAN_NUM-1:0]        gnt_o,
  output logic                       ram_rd_en_o,
  output logic [CW+ADDR_W:0]         ram_rd_addr_o,
  input  logic [DATA_W-1:0]          ram_rd_data_i,
  output logic [CHAN_NUM-1:0]        rd_vld_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       bank_o,
  output logic                       frame_start_o
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     scan_idx;
  logic [CW-1:0]     gnt_idx;
  logic              gnt_found;
  logic              gnt_any;
  logic              flip;
  logic [ADDR_W-1:0] gnt_addr;
  logic [RD_LAT-1:0] pipe_vld;
  logic [CW-1:0]     pipe_id [RD_LAT];

  // Round-robin search: first requesting channel at or above ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < CHAN_NUM; i++) begin
      scan_idx = ptr + CW'(i);
      if (!gnt_found && req_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Select the address of the granted channel.
  always_comb begin
    gnt_addr = '0;
    for (int k = 0; k < CHAN_NUM; k++) begin
      if (gnt_idx == CW'(k)) begin
        gnt_addr = req_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a finished frame stops new grants until reads drain.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (ram_wr_done_i) state_nxt = DRAIN;
      DRAIN:   if (pipe_vld == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs: grants only in RUN, bank flip once the pipeline is empty.
  always_comb begin
    gnt_any = (state == RUN) && gnt_found;
    flip    = (state == DRAIN) && (pipe_vld == '0);
    gnt_o   = '0;
    if (gnt_any) begin
      gnt_o[gnt_idx] = 1'b1;
    end
  end

  assign ram_rd_en_o   = gnt_any;
  assign ram_rd_addr_o = {bank_o, gnt_idx, gnt_addr};
  assign rd_data_o     = ram_rd_data_i;

  // Arbitration pointer, display bank and frame-start pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr           <= '0;
      bank_o        <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      if (gnt_any) begin
        ptr <= gnt_idx + CW'(1);
      end
      if (flip) begin
        bank_o <= ~bank_o;
      end
      frame_start_o <= flip;
    end
  end

  // Return pipeline tracking which channel each outstanding read belongs to.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_id[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= gnt_any;
      pipe_id[0]  <= gnt_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  // Decode the last pipeline stage into a one-hot return-valid.
  always_comb begin
    rd_vld_o = '0;
    if (pipe_vld[RD_LAT-1]) begin
      rd_vld_o[pipe_id[RD_LAT-1]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_rd_sched.sv
// tb_ram_rd_sched: directed bench for ram_rd_sched with a RAM model and a
// scoreboard of expected read returns keyed by the cycle they are due.
module tb_ram_rd_sched;

  localparam int CHAN_NUM = 16;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 2;
  localparam int AW       = 1 + 4 + ADDR_W;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       done = 1'b0;
  logic [CHAN_NUM-1:0]        req = '0;
  logic [CHAN_NUM*ADDR_W-1:0] req_addr = '0;
  logic [CHAN_NUM-1:0]        gnt;
  logic                       rd_en;
  logic [AW-1:0]              rd_addr;
  logic [DATA_W-1:0]          ram_data;
  logic [CHAN_NUM-1:0]        rd_vld;
  logic [DATA_W-1:0]          rd_data;
  logic                       bank;
  logic                       frame_start;
  logic [DATA_W-1:0]          ram_q1 = '0;
  logic [DATA_W-1:0]          ram_q2 = '0;

  typedef struct {
    int                  due;
    logic [CHAN_NUM-1:0] vld;
    logic [DATA_W-1:0]   data;
  } sb_t;

  sb_t        sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] addr_tab [CHAN_NUM];

  ram_rd_sched #(
    .CHAN_NUM(CHAN_NUM),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ram_wr_done_i(done),
    .req_i        (req),
    .req_addr_i   (req_addr),
    .gnt_o        (gnt),
    .ram_rd_en_o  (rd_en),
    .ram_rd_addr_o(rd_addr),
    .ram_rd_data_i(ram_data),
    .rd_vld_o     (rd_vld),
    .rd_data_o    (rd_data),
    .bank_o       (bank),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  // Word stored at a full RAM address: distinct per bank, channel and address.
  function automatic logic [DATA_W-1:0] ram_word(input logic [AW-1:0] a);
    return {6'h2B, a, ~a};
  endfunction

  function automatic int onehotIdx(input logic [CHAN_NUM-1:0] v);
    int r;
    r = 0;
    for (int k = 0; k < CHAN_NUM; k++) begin
      if (v[k]) r = k;
    end
    return r;
  endfunction

  // RAM model with two cycles of read latency.
  always @(posedge clk) begin
    ram_q1 <= rd_en ? ram_word(rd_addr) : 32'hDEAD_BEEF;
    ram_q2 <= ram_q1;
  end
  assign ram_data = ram_q2;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic loadAddr();
    for (int k = 0; k < CHAN_NUM; k++) begin
      req_addr[k*ADDR_W +: ADDR_W] = addr_tab[k];
    end
  endtask

  // One clock cycle: drive inputs, check grant/bank/frame-start, record any
  // granted read in the scoreboard, and check the return port.
  task automatic applyStimulus(input logic [CHAN_NUM-1:0] r, input logic d,
                               input logic [CHAN_NUM-1:0] exp_gnt, input logic exp_bank,
                               input logic exp_fs, input string tag);
    int            idx;
    logic [AW-1:0] ea;
    nextCycle();
    req  = r;
    done = d;
    #1;
    checkOutput({tag, "/gnt"}, 64'(gnt), 64'(exp_gnt));
    checkOutput({tag, "/rd_en"}, 64'(rd_en), 64'(exp_gnt != '0));
    if (exp_gnt != '0) begin
      idx = onehotIdx(exp_gnt);
      ea  = {exp_bank, idx[3:0], addr_tab[idx]};
      checkOutput({tag, "/addr"}, 64'(rd_addr), 64'(ea));
      sb.push_back('{cyc + RD_LAT, exp_gnt, ram_word(ea)});
    end
    checkOutput({tag, "/bank"}, 64'(bank), 64'(exp_bank));
    checkOutput({tag, "/frame_start"}, 64'(frame_start), 64'(exp_fs));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      checkOutput({tag, "/rd_vld"}, 64'(rd_vld), 64'(sb[0].vld));
      checkOutput({tag, "/rd_data"}, 64'(rd_data), 64'(sb[0].data));
      void'(sb.pop_front());
    end else begin
      checkOutput({tag, "/rd_vld_idle"}, 64'(rd_vld), 64'(0));
    end
  endtask

  // Assert reset for a few cycles; pending reads are expected to be lost.
  task automatic doReset(input string tag);
    nextCycle();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    sb.delete();
    #1;
    checkOutput({tag, "/gnt"}, 64'(gnt), 64'(0));
    checkOutput({tag, "/rd_en"}, 64'(rd_en), 64'(0));
    checkOutput({tag, "/rd_vld"}, 64'(rd_vld), 64'(0));
    checkOutput({tag, "/bank"}, 64'(bank), 64'(0));
    checkOutput({tag, "/frame_start"}, 64'(frame_start), 64'(0));
    repeat (2) nextCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < CHAN_NUM; k++) begin
      addr_tab[k] = 8'((k << 4) | (15 - k));
    end
    addr_tab[3] = 8'h05;
    loadAddr();

    // Reset and first grant from ptr = 0.
    doReset("reset");
    applyStimulus(16'hFFFF, 1'b0, 16'h0001, 1'b0, 1'b0, "reset_first");

    // Single read on channel 3.
    applyStimulus(16'h0008, 1'b0, 16'h0008, 1'b0, 1'b0, "single");
    repeat (3) applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "single_ret");

    // Round-robin fairness from a fresh pointer.
    doReset("reset_rr");
    for (int i = 0; i < 50; i++) begin
      applyStimulus(16'hFFFF, 1'b0, 16'(1) << (i % 16), 1'b0, 1'b0, "rr_all");
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'h8001, 1'b0, (i % 2 == 0) ? 16'h8000 : 16'h0001, 1'b0, 1'b0, "rr_8001");
    end

    // Frame flip with reads in flight.
    applyStimulus(16'hFFFF, 1'b1, 16'h0002, 1'b0, 1'b0, "flip_t");
    repeat (3) applyStimulus(16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, "flip_drain");
    applyStimulus(16'hFFFF, 1'b0, 16'h0004, 1'b1, 1'b1, "flip_t4");
    applyStimulus(16'hFFFF, 1'b0, 16'h0008, 1'b1, 1'b0, "flip_t5");
    repeat (3) applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, "flip_idle");

    // Done pulses during DRAIN are absorbed; one in the frame-start cycle re-flips.
    applyStimulus(16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, "md_c0");
    repeat (3) applyStimulus(16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "md_drain");
    applyStimulus(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, "md_fs");
    applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "md_drain2");
    applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, "md_fs2");
    applyStimulus(16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "md_done3");
    applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, "md_drain3");
    applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, "md_back0");

    // Flip to bank 1, then reset in the middle of the next drain.
    applyStimulus(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, "pre_done");
    applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "pre_drain");
    applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, "pre_fs");
    applyStimulus(16'hFFFF, 1'b1, 16'h0020, 1'b1, 1'b0, "rst_t");
    applyStimulus(16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, "rst_drain");
    doReset("rst_mid");
    repeat (3) applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "post_rst_idle");
    applyStimulus(16'hFFFF, 1'b0, 16'h0001, 1'b0, 1'b0, "post_rst");
    repeat (3) applyStimulus(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "post_rst_ret");

    checkOutput("sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
